// File: rtl/sa_matmul_engine.sv
// X_R x S by S x N matrix multiply in Q2.13, one reduction step per cycle across all outputs.
// Define SA_SAT_EN for saturating accumulation; otherwise accumulator adds wrap.

module sa_mac_lane (
    input  logic [15:0] acc_i,
    input  logic [15:0] x_i,
    input  logic [15:0] w_i,
    output logic [15:0] acc_o
);
    logic signed [31:0] prod;
    logic [15:0] mul;
    logic [15:0] sum;
    logic        unused_prod;

    assign prod = 32'($signed(x_i)) * 32'($signed(w_i));
    // Q2.13 * Q2.13 = Q4.26; keep the sign and drop two integer bits to return to Q2.13.
    assign mul  = {prod[31], prod[27:13]};
    assign sum  = acc_i + mul;
    assign unused_prod = ^{prod[30:28], prod[12:0]};

`ifdef SA_SAT_EN
    logic ovf;
    assign ovf   = (acc_i[15] == mul[15]) && (sum[15] != acc_i[15]);
    assign acc_o = ovf ? (acc_i[15] ? 16'h8000 : 16'h7FFF) : sum;
`else
    assign acc_o = sum;
`endif
endmodule

module sa_matmul_engine #(
    parameter int S   = 64,
    parameter int X_R = 2,
    parameter int N   = 64
) (
    input  logic                   I_CLK,
    input  logic                   I_RST_N,
    input  logic                   I_START_FLAG,
    input  logic                   I_ACC_MODE,
    input  logic [X_R*S*16-1:0]    I_X,
    input  logic [S*N*16-1:0]      I_W,
    output logic                   O_BUSY,
    output logic                   O_OUT_VLD,
    output logic [X_R*N*16-1:0]    O_OUT
);
    localparam int KW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_COMPUTE, ST_DONE} state_e;

    state_e                         state_q;
    logic [KW-1:0]                  k_q;
    logic [X_R-1:0][S-1:0][15:0]    x_q;
    logic [S-1:0][N-1:0][15:0]      w_q;
    logic [X_R-1:0][N-1:0][15:0]    acc_q;
    logic [X_R-1:0][N-1:0][15:0]    acc_d;
    logic [X_R-1:0][N-1:0][15:0]    out_q;
    logic                           busy_q;
    logic                           vld_q;

    // Packed layouts match the flat port bit ordering, so element [a][b] lines up directly.
    for (genvar i = 0; i < X_R; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            sa_mac_lane u_lane (
                .acc_i (acc_q[i][j]),
                .x_i   (x_q[i][k_q]),
                .w_i   (w_q[k_q][j]),
                .acc_o (acc_d[i][j])
            );
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            x_q     <= '0;
            w_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (I_START_FLAG) begin
                        x_q     <= I_X;
                        w_q     <= I_W;
                        acc_q   <= I_ACC_MODE ? out_q : '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    acc_q <= acc_d;
                    if (k_q == KW'(S - 1)) begin
                        k_q     <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                ST_DONE: begin
                    out_q   <= acc_q;
                    vld_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_BUSY    = busy_q;
    assign O_OUT_VLD = vld_q;
    assign O_OUT     = out_q;
endmodule

// File: doc/sa_matmul_engine.md
SA_MATMUL_ENGINE -- requirements
Module: sa_matmul_engine

Interface
REQ-001 SHALL have parameter S, default 64: reduction depth; X is X_R x S, W is S x N; S>=1.
REQ-002 SHALL have parameter X_R, default 2: X row count; X_R>=1.
REQ-003 SHALL have parameter N, default 64: W and OUT column count; N>=1.
REQ-004 SHALL have port I_CLK, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port I_RST_N, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port I_START_FLAG, input, 1: start request, one-cycle pulse, sampled in IDLE only.
REQ-007 SHALL have port I_ACC_MODE, input, 1: 1 = accumulate onto the current O_OUT, 0 = start from zero; sampled with start.
REQ-008 SHALL have port I_X, input, X_R*S*16: element [i][k] at bits (i*S+k)*16 +: 16, Q2.13 signed.
REQ-009 SHALL have port I_W, input, S*N*16: element [k][j] at bits (k*N+j)*16 +: 16, Q2.13 signed.
REQ-010 SHALL have port O_BUSY, output, 1: high while in COMPUTE or DONE.
REQ-011 SHALL have port O_OUT_VLD, output, 1: one-cycle pulse when a new O_OUT is presented.
REQ-012 SHALL have port O_OUT, output, X_R*N*16: element [i][j] at bits (i*N+j)*16 +: 16, Q2.13 signed, held between results.

Function
REQ-013 SHALL implement FSM IDLE -> COMPUTE -> DONE -> IDLE.
REQ-014 IDLE with I_START_FLAG=1 at edge T0 SHALL latch I_X, I_W and I_ACC_MODE, set k=0, and enter COMPUTE; I_X and I_W may change after T0 without effect.
REQ-015 At T0 each accumulator SHALL load O_OUT[i][j] if I_ACC_MODE=1, else 0.
REQ-016 Each COMPUTE edge SHALL update every acc[i][j] += mul(X[i][k], W[k][j]) for all i,j in parallel, then increment k.
REQ-017 mul SHALL be the 32-bit signed product c of two Q2.13 values, truncated to {c[31], c[27:13]}.
REQ-018 COMPUTE SHALL last exactly S cycles (edges T1..TS) and then enter DONE; S=1 SHALL give one COMPUTE cycle.
REQ-019 The DONE edge (T0+S+1) SHALL copy the accumulators into O_OUT, pulse O_OUT_VLD for one cycle, and return to IDLE.
REQ-020 Latency SHALL be: O_OUT_VLD high in the cycle after edge T0+S+1; back-to-back start accepted at edge T0+S+2 at the earliest.
REQ-021 I_START_FLAG SHALL be ignored outside IDLE, with no queuing.
REQ-022 O_OUT SHALL change only on the DONE edge or on reset.
REQ-023 Accumulator add overflow behaviour SHALL be as set under Configuration.

Reset
REQ-024 I_RST_N low SHALL immediately force FSM=IDLE, k=0, accumulators=0, O_OUT=0, O_OUT_VLD=0, O_BUSY=0.
REQ-025 Reset during COMPUTE or DONE SHALL abort the operation with no O_OUT_VLD pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-026 Macro SA_SAT_EN defined: each accumulator add SHALL saturate to 0x7FFF on positive overflow and 0x8000 on negative overflow.
REQ-027 SA_SAT_EN undefined: each accumulator add SHALL wrap modulo 2^16 (two's complement).

Verification
REQ-028 S=2, X_R=2, N=4, all X=W=0x2000 (1.0), ACC_MODE=0 -> all O_OUT=0x4000, O_OUT_VLD pulse 4 cycles after the start edge, O_BUSY high for 3 cycles.
REQ-029 S=1, X=0xE000 (-1.0), W=0x2000, ACC_MODE=0 -> all O_OUT=0xE000.
REQ-030 S=4, all X=W=0x3000 (1.5; product 0x4800) -> O_OUT=0x7FFF with SA_SAT_EN, 0x2000 without.
REQ-031 S=2, all X=W=0x1000 (0.5): run with ACC_MODE=0 -> 0x1000; run again with ACC_MODE=1 -> 0x2000.
REQ-032 Start pulse during COMPUTE -> ignored: exactly one O_OUT_VLD pulse and result unchanged; change I_X after T0 -> result unaffected.
REQ-033 I_RST_N low at k=1 of a run -> O_OUT=0, no O_OUT_VLD pulse; a following clean run gives the correct result.
